// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU: machine constants,
// the fetch FSM encoding and the IF/ID register layout used by fetch and decode.
package cpu_pkg;

    localparam int XLEN = 16;

    localparam logic [XLEN-1:0] PC_STEP    = 16'd2;
    localparam logic [XLEN-1:0] NOP_INSTR  = 16'h0000;
    localparam logic [XLEN-1:0] HALT_INSTR = 16'hF000;
    localparam logic [XLEN-1:0] RESET_PC   = 16'h0000;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            valid;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Bubble wins over load; with neither asserted the
// register holds, which is how a stall freezes decode's view.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP = NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            bubble,
    input  logic [XLEN-1:0] instr_in,
    input  logic [XLEN-1:0] pc_in,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic            valid
);

    if_id_t if_id_q;
    if_id_t if_id_d;

    always_comb begin
        if_id_d = if_id_q;
        if (bubble) begin
            if_id_d.instr = NOP;
            if_id_d.pc    = '0;
            if_id_d.valid = 1'b0;
        end else if (load) begin
            if_id_d.instr = instr_in;
            if_id_d.pc    = pc_in;
            if_id_d.valid = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_q.instr <= NOP;
            if_id_q.pc    <= '0;
            if_id_q.valid <= 1'b0;
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign instr = if_id_q.instr;
    assign pc    = if_id_q.pc;
    assign valid = if_id_q.valid;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: program counter, RUN/HALTED fetch FSM and IF/ID register control.
// Build with FETCH_COUNT_EN defined to get a saturating fetched-instruction counter.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = cpu_pkg::RESET_PC,
    parameter logic [XLEN-1:0] HALT_INSTR = cpu_pkg::HALT_INSTR,
    parameter logic [XLEN-1:0] NOP_INSTR  = cpu_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] pc,
    input  logic [15:0] instruction,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc,
    output logic        if_id_valid,
    output logic        halted,
    output logic [15:0] fetch_count
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus2;
    logic            load;
    logic            bubble;

    assign pc_plus2 = pc_q + PC_STEP;

    // A redirect also pulls us out of HALTED: the HALT was on a wrong path.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        load    = 1'b0;
        bubble  = 1'b0;
        if (redirect) begin
            pc_d    = redirect_pc & ~16'h0001;
            bubble  = 1'b1;
            state_d = RUN;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (state_q == RUN) begin
            load = 1'b1;
            if (instruction == HALT_INSTR) begin
                state_d = HALTED;
            end else begin
                pc_d = pc_plus2;
            end
        end else begin
            bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    if_id_reg #(
        .NOP (NOP_INSTR)
    ) u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .bubble   (bubble),
        .instr_in (instruction),
        .pc_in    (pc_plus2),
        .instr    (if_id_instr),
        .pc       (if_id_pc),
        .valid    (if_id_valid)
    );

`ifdef FETCH_COUNT_EN
    logic [XLEN-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign fetch_count = count_q;
`else
    assign fetch_count = 16'h0000;
`endif

    assign pc     = pc_q;
    assign halted = (state_q == HALTED);

endmodule
